imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams bytes into little-endian 32-bit words.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int DEPTH = 13
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  num_words,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_DONE
    } state_t;
`endif

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_t      state_q, state_d;
    logic [7:0]  nwords_q, nwords_d;
    logic [7:0]  widx_q, widx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] acc_q, acc_d;
    logic        error_q, error_d;
    logic        byte_ready_q, byte_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic start_ok;
    logic xfer;
    logic last_word;

    assign start_ok  = (num_words != 8'd0) && ({1'b0, num_words} <= DEPTH_W);
    assign xfer      = byte_valid && byte_ready_q;
    assign last_word = (widx_q + 8'd1) == nwords_q;

    always_comb begin
        state_d  = state_q;
        nwords_d = nwords_q;
        widx_d   = widx_q;
        bcnt_d   = bcnt_q;
        acc_d    = acc_q;
        error_d  = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (start_ok) begin
                        nwords_d = num_words;
                        widx_d   = 8'd0;
                        bcnt_d   = 2'd0;
                        acc_d    = 32'd0;
                        error_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d   = 8'd0;
`endif
                        state_d  = S_LOAD;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    // Shift in at the top so the first byte lands in 7:0.
                    acc_d  = {byte_in, acc_q[31:8]};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    if (bcnt_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                widx_d = widx_q + 8'd1;
                if (!last_word) begin
                    state_d = S_LOAD;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    if (byte_in == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        byte_ready_d = (state_d == S_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_ready_d = byte_ready_d || (state_d == S_CHECK);
`endif
        mem_we_d    = (state_d == S_WRITE);
        mem_wdata_d = mem_wdata_q;
        mem_addr_d  = mem_addr_q;
        if (state_d == S_WRITE) begin
            mem_wdata_d = acc_d;
            mem_addr_d  = {54'd0, widx_q, 2'b00};
        end
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        cpu_hold_d = !done_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            nwords_q     <= 8'd0;
            widx_q       <= 8'd0;
            bcnt_q       <= 2'd0;
            acc_q        <= 32'd0;
            error_q      <= 1'b0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 64'd0;
            mem_wdata_q  <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_hold_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            nwords_q     <= nwords_d;
            widx_q       <= widx_d;
            bcnt_q       <= bcnt_d;
            acc_q        <= acc_d;
            error_q      <= error_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cpu_hold_q   <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_hold   = cpu_hold_q;

endmodule
